// File: rtl/pulse_gen_pkg.sv
// Shared types and Gray-code helpers for the pulse generator sequencer.
// Helpers work on a fixed maximum width; callers zero-extend and truncate.
package pulse_gen_pkg;

  localparam int GW_MAX = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [GW_MAX-1:0] gray2bin(input logic [GW_MAX-1:0] g);
    logic [GW_MAX-1:0] b;
    b[GW_MAX-1] = g[GW_MAX-1];
    for (int i = GW_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Next Gray code within an n-bit field; the all-ones binary value wraps to 0.
  function automatic logic [GW_MAX-1:0] gray_inc(input logic [GW_MAX-1:0] g, input int n);
    logic [GW_MAX-1:0] mask;
    logic [GW_MAX-1:0] b;
    mask = {GW_MAX{1'b1}} >> (GW_MAX - n);
    b    = (gray2bin(g) + GW_MAX'(1)) & mask;
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_phase_cnt.sv
// Gray-coded phase register with synchronous clear and advance enable.
// Clear wins over enable; the binary decode is exported for comparisons.
module gray_phase_cnt
  import pulse_gen_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  logic [N-1:0] gray_q;
  logic [N-1:0] gray_d;

  always_comb begin
    gray_d = gray_q;
    if (clr) begin
      gray_d = '0;
    end else if (en) begin
      gray_d = N'(gray_inc(GW_MAX'(gray_q), N));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign gray = gray_q;
  assign bin  = N'(gray2bin(GW_MAX'(gray_q)));

endmodule

// File: rtl/pulse_gen_ctrl.sv
// Pulse burst sequencer: latches period/width/burst on start and drives a
// registered pulse from a Gray phase timebase; stop aborts, P=0 is rejected.
module pulse_gen_ctrl
  import pulse_gen_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] period,
  input  logic [N-1:0] width,
  input  logic [N-1:0] burst,
  output logic         pulse_out,
  output logic         busy,
  output logic         done,
  output logic         aborted,
  output logic         err,
  output logic [N-1:0] gray_out
);

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state_q, state_d;
  logic [N-1:0] p_q, p_d;
  logic [N-1:0] w_q, w_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] rem_q, rem_d;
  logic         pulse_q, pulse_d;
  logic         done_q, done_d;
  logic         aborted_q, aborted_d;
  logic         err_q, err_d;
  logic         phase_clr;
  logic         phase_en;
  logic [N-1:0] phase_bin;
  logic [N-1:0] phase_nxt;

  gray_phase_cnt #(.N(N)) u_phase (
    .clk  (clk),
    .rst  (rst),
    .clr  (phase_clr),
    .en   (phase_en),
    .gray (gray_out),
    .bin  (phase_bin)
  );

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    w_d       = w_q;
    b_d       = b_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = 1'b0;
    phase_clr = 1'b0;
    phase_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Phase is held at zero so gray_out reads 0 whenever idle.
        phase_clr = 1'b1;
        if (start && !stop) begin
          if (period == '0) begin
            err_d = 1'b1;
          end else begin
            p_d     = period;
            w_d     = width;
            b_d     = burst;
            rem_d   = burst;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          phase_clr = 1'b1;
        end else if (tick) begin
          if (phase_bin == p_q - ONE) begin
            phase_clr = 1'b1;
            if (b_q != '0 && rem_q == ONE) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (b_q != '0) begin
              rem_d = rem_q - ONE;
            end
          end else begin
            phase_en = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    phase_nxt = phase_clr ? '0 : (phase_en ? phase_bin + ONE : phase_bin);
    pulse_d   = (state_d == ST_RUN) && (phase_nxt < w_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      p_q       <= '0;
      w_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      pulse_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      w_q       <= w_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      pulse_q   <= pulse_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err       = err_q;

endmodule
